// File: rtl/super_alu_seq.sv
// Sequenced expression unit: (n1 op1 n2) op2 (n3 op3 n4) computed over three cycles
// on one shared 16-bit ALU, with valid/ready handshakes on both sides.
module super_alu_seq #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [40:0]      in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [2:0] {StIdle, StS1, StS2, StS3, StDone} state_e;

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a,
                                      input logic [15:0] b);
    logic [15:0] res;
    logic [15:0] p;
    logic [15:0] sq;
    logic [15:0] root;
    logic [15:0] trial;
    logic [3:0]  e;
    res   = '0;
    p     = 16'd1;
    sq    = a;
    root  = '0;
    trial = '0;
    e     = '0;
    case (op)
      3'b000:          res = a + b;
      3'b001, 3'b011:  res = a - b;
      3'b010:          res = a * b;
      3'b100: begin
        // Square-and-multiply over a 4-bit exponent; wrap is harmless mod 2^16
        e = (b != 16'd0 && b <= 16'd12) ? b[3:0] : 4'd13;
        for (int i = 0; i < 4; i++) begin
          if (e[i]) p = p * sq;
          sq = sq * sq;
        end
        res = p;
      end
      3'b101: begin
        if (a[15])            res = '0;
        else if (a == 16'd0)  res = 16'hFFFF;
        else begin
          for (int i = 0; i < 15; i++) begin
            if (a[i]) res = 16'(i);
          end
        end
      end
      3'b110: begin
        if (!a[15]) begin
          for (int i = 7; i >= 0; i--) begin
            trial = root | (16'd1 << i);
            if (trial * trial <= a) root = trial;
          end
        end
        res = root;
      end
      default:         res = '0;
    endcase
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
  logic [15:0]       n1_q, n1_d, n2_q, n2_d, n3_q, n3_d, n4_q, n4_d;
  logic [15:0]       r1_q, r1_d, r2_q, r2_d, out_q, out_d;
  logic              out_valid_q, out_valid_d, err_q, err_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;

  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_res;
  logic        accept;

  assign in_ready  = (state_q == StIdle) || (state_q == StDone && out_ready);
  assign accept    = in_valid && in_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign busy      = (state_q != StIdle);
  assign done_cnt  = done_cnt_q;

  always_comb begin
    alu_op = op1_q;
    alu_a  = n1_q;
    alu_b  = n2_q;
    case (state_q)
      StS2: begin
        alu_op = op3_q;
        alu_a  = n3_q;
        alu_b  = n4_q;
      end
      StS3: begin
        alu_op = op2_q;
        alu_a  = r1_q;
        alu_b  = r2_q;
      end
      default: ;
    endcase
    alu_res = alu(alu_op, alu_a, alu_b);
  end

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    op3_d       = op3_q;
    n1_d        = n1_q;
    n2_d        = n2_q;
    n3_d        = n3_q;
    n4_d        = n4_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    done_cnt_d  = done_cnt_q;

    case (state_q)
      StIdle: if (accept) state_d = StS1;
      StS1: begin
        r1_d    = alu_res;
        err_d   = err_q | (alu_op == 3'b111);
        state_d = StS2;
      end
      StS2: begin
        r2_d    = alu_res;
        err_d   = err_q | (alu_op == 3'b111);
        state_d = StS3;
      end
      StS3: begin
        out_d       = alu_res;
        out_valid_d = 1'b1;
        err_d       = err_q | (alu_op == 3'b111);
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + 1'b1;
          state_d     = in_valid ? StS1 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      op1_d = in[40:38];
      op2_d = in[37:35];
      op3_d = in[34:32];
      n1_d  = {{8{in[31]}}, in[31:24]};
      n2_d  = {{8{in[23]}}, in[23:16]};
      n3_d  = {{8{in[15]}}, in[15:8]};
      n4_d  = {{8{in[7]}},  in[7:0]};
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op1_q       <= '0;
      op2_q       <= '0;
      op3_q       <= '0;
      n1_q        <= '0;
      n2_q        <= '0;
      n3_q        <= '0;
      n4_q        <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      op3_q       <= op3_d;
      n1_q        <= n1_d;
      n2_q        <= n2_d;
      n3_q        <= n3_d;
      n4_q        <= n4_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

endmodule

// File: doc/super_alu_seq.md
Name: super_alu_seq

Overview:
- Sequenced, area-reduced version of the three-ALU expression unit.
- Computes (#1 op1 #2) op2 (#3 op3 #4) from the same 41-bit instruction word.
- Uses one shared 16-bit ALU instance over three clock cycles instead of three parallel ALUs.
- Has a valid/ready handshake on input and output.
- Sits between the instruction source and the result consumer; holds the result until the consumer takes it.

Parameters:
- CNT_W, 16, width of the completed-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  41  instruction word:
  - [40:38] op1, [37:35] op2, [34:32] op3
  - [31:24] num1, [23:16] num2, [15:8] num3, [7:0] num4
- in_valid  input  1  instruction present on in.
- in_ready  output  1  block can accept an instruction.
- out  output  16  result, held stable while out_valid=1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- err  output  1  at least one of the three ops was illegal (3'b111); qualified by out_valid.
- busy  output  1  high in any state other than IDLE.
- done_cnt  output  CNT_W  number of completed output handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge): state=IDLE, out=0, out_valid=0, err=0, done_cnt=0, all internal operand/result registers=0.
- Reset in any state, including mid-sequence, drops the in-flight instruction. No partial output.
- Input capture: on in_valid && in_ready, register the three ops and the four operands.
  - Each 8-bit operand is sign-extended to 16 bits: bit 7 replicated into [15:8].
- in_ready:
  - 1 in IDLE.
  - 1 in DONE when out_ready=1, which allows back-to-back instructions.
  - 0 otherwise.
- FSM:
  - IDLE: on accept -> S1.
  - S1: ALU(op1, n1, n2) -> r1; -> S2.
  - S2: ALU(op3, n3, n4) -> r2; -> S3.
  - S3: ALU(op2, r1, r2) -> out; set out_valid=1; -> DONE.
  - DONE: hold out, err, out_valid.
    - If out_ready=1 and in_valid=1: accept the new word, clear out_valid, done_cnt+1, -> S1.
    - If out_ready=1 and in_valid=0: clear out_valid, done_cnt+1, -> IDLE.
- Latency: accept at edge N, out_valid=1 after edge N+3. Throughput: one instruction per 4 cycles with out_ready held high.
- err = OR of (op==3'b111) over the three ops. It is computed in the stage that uses each op and cleared on accept.
- ALU semantics (a=first operand, b=second operand, 16-bit wrap on all results):
  - 000: a+b.
  - 001 and 011: a-b.
  - 010: low 16 bits of a*b.
  - 100: power.
    - b in 1..12: a^b.
    - b=0 or b>=13: a^13.
    - Truncated to 16 bits.
  - 101: log2.
    - a[15]=1: 0.
    - a=0: 16'hFFFF.
    - Otherwise floor(log2 a).
    - b ignored.
  - 110: sqrt.
    - a[15]=1: 0.
    - Otherwise floor(sqrt a).
    - b ignored.
  - 111: illegal; result 0.
- The ALU is purely combinational between the stage registers; a single instance is shared by S1–S3.
- in changing while not accepted has no effect. out does not change while out_valid=1 and out_ready=0.

Test Plan:
- Basic: in=41'h011_0304_0A02 ((3+4)*(10-2)), in_valid pulse, out_ready=1 -> out_valid 3 cycles after accept, out=16'h0038, err=0, done_cnt=1.
- Sign-extension and power:
  - Fields: op1=000, op2=010, op3=100; num1=0xFF, num2=0x02, num3=0x02, num4=0x05.
  - Expected: r1=1, r2=32, out=16'h0020.
  - Also op1=100 with num1=0x02, num2=0x00 -> r1=16'h2000.
- Unary ops:
  - Fields: op1=110, op2=000, op3=101; num1=0x64, num3=0x40.
  - Expected: out=10+6=16'h0010.
  - Separately: sqrt of num1=0x80 -> 0; log2 of 0 -> 16'hFFFF.
- Illegal op: op3=111 with otherwise legal fields -> r2=0, err=1 with out_valid; the next legal instruction returns err=0.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles -> out/out_valid stable, in_ready=0.
  - Raise out_ready with in_valid=1 -> new word accepted the same cycle, done_cnt increments once, second result 4 cycles after the first.
- Reset mid-operation: assert rst in S2 -> next cycle IDLE, out_valid=0, out=0, done_cnt=0, in_ready=1; the subsequent instruction computes correctly.
